// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-cache memory port arbiter: FSM states, op encoding, width defaults.
package mem_port_arbiter_pkg;

   localparam int ADDR_W_DEF  = 8;
   localparam int WDATA_W_DEF = 8;
   localparam int RDATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick, combinational: a lone requester wins, a tie goes to the one not served last.
module rr_pick2 (
   input  logic [1:0] pending,
   input  logic       last,
   output logic       grant_valid,
   output logic       grant_idx
);

   always_comb begin
      grant_valid = |pending;
      grant_idx   = 1'b0;
      if (pending == 2'b11) begin
         grant_idx = ~last;
      end else begin
         grant_idx = pending[1];
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between two caches: round-robin grant, command latched on grant (1 cycle),
// completion forwarded combinationally to the owner only; grant held until the owner drops its request.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int WDATA_W = WDATA_W_DEF,
   parameter int RDATA_W = RDATA_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               C0Read_request,
   input  logic               C0Write_request,
   input  logic [ADDR_W-1:0]  C0Address,
   input  logic [WDATA_W-1:0] C0Write_data,
   output logic               C0Read_ready,
   output logic [RDATA_W-1:0] C0Read_data,
   output logic               C0Write_done,
   input  logic               C1Read_request,
   input  logic               C1Write_request,
   input  logic [ADDR_W-1:0]  C1Address,
   input  logic [WDATA_W-1:0] C1Write_data,
   output logic               C1Read_ready,
   output logic [RDATA_W-1:0] C1Read_data,
   output logic               C1Write_done,
   output logic               MRead_request,
   output logic               MWrite_request,
   output logic [ADDR_W-1:0]  MAddress,
   output logic [WDATA_W-1:0] MWrite_data,
   input  logic               MRead_ready,
   input  logic [RDATA_W-1:0] MRead_data,
   input  logic               MWrite_done
);

   state_t     state;
   state_t     state_nxt;
   logic       owner;
   logic       op;
   logic       last;
   logic [1:0] pending;
   logic       grant_valid;
   logic       grant_idx;
   logic       grant_op;
   logic       done_in;
   logic       owner_req;

   assign pending = {C1Read_request | C1Write_request, C0Read_request | C0Write_request};

   rr_pick2 u_pick (
      .pending     (pending),
      .last        (last),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // A requester raising read and write together gets its read first.
   assign grant_op  = grant_idx ? (C1Read_request ? OP_READ : OP_WRITE)
                                : (C0Read_request ? OP_READ : OP_WRITE);
   assign done_in   = (op == OP_WRITE) ? MWrite_done : MRead_ready;
   assign owner_req = owner ? ((op == OP_WRITE) ? C1Write_request : C1Read_request)
                            : ((op == OP_WRITE) ? C0Write_request : C0Read_request);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_valid) state_nxt = BUSY;
         BUSY:    if (done_in)     state_nxt = RELEASE;
         RELEASE: if (!owner_req)  state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   // Completions reach only the owner and only while BUSY, so late or stale pulses are dropped.
   always_comb begin
      C0Read_ready = 1'b0;
      C1Read_ready = 1'b0;
      C0Write_done = 1'b0;
      C1Write_done = 1'b0;
      if (state == BUSY) begin
         if (op == OP_READ) begin
            C0Read_ready = !owner && MRead_ready;
            C1Read_ready =  owner && MRead_ready;
         end else begin
            C0Write_done = !owner && MWrite_done;
            C1Write_done =  owner && MWrite_done;
         end
      end
   end

   assign C0Read_data = MRead_data;
   assign C1Read_data = MRead_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner          <= 1'b0;
         op             <= OP_READ;
         last           <= 1'b1;
         MRead_request  <= 1'b0;
         MWrite_request <= 1'b0;
         MAddress       <= '0;
         MWrite_data    <= '0;
      end else begin
         if (state == IDLE && grant_valid) begin
            owner          <= grant_idx;
            op             <= grant_op;
            MAddress       <= grant_idx ? C1Address : C0Address;
            MWrite_data    <= grant_idx ? C1Write_data : C0Write_data;
            MRead_request  <= (grant_op == OP_READ);
            MWrite_request <= (grant_op == OP_WRITE);
         end
         if (state == BUSY && done_in) begin
            MRead_request  <= 1'b0;
            MWrite_request <= 1'b0;
            last           <= owner;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every cycle, plus literal checks.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        C0Read_request, C0Write_request, C1Read_request, C1Write_request;
   logic [7:0]  C0Address, C1Address, C0Write_data, C1Write_data;
   logic        C0Read_ready, C1Read_ready, C0Write_done, C1Write_done;
   logic [31:0] C0Read_data, C1Read_data;
   logic        MRead_request, MWrite_request;
   logic [7:0]  MAddress, MWrite_data;
   logic        MRead_ready, MWrite_done;
   logic [31:0] MRead_data;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .C0Read_request(C0Read_request), .C0Write_request(C0Write_request),
      .C0Address(C0Address), .C0Write_data(C0Write_data),
      .C0Read_ready(C0Read_ready), .C0Read_data(C0Read_data), .C0Write_done(C0Write_done),
      .C1Read_request(C1Read_request), .C1Write_request(C1Write_request),
      .C1Address(C1Address), .C1Write_data(C1Write_data),
      .C1Read_ready(C1Read_ready), .C1Read_data(C1Read_data), .C1Write_done(C1Write_done),
      .MRead_request(MRead_request), .MWrite_request(MWrite_request),
      .MAddress(MAddress), .MWrite_data(MWrite_data),
      .MRead_ready(MRead_ready), .MRead_data(MRead_data), .MWrite_done(MWrite_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: one open transaction at a time; it is "done" once memory answered,
   // and closes when the owner lets go of the request it was granted for.
   bit       txn_open = 1'b0;
   bit       txn_done = 1'b0;
   bit       m_owner  = 1'b0;
   bit       m_wr     = 1'b0;
   bit       m_last   = 1'b1;
   bit [7:0] m_addr   = 8'h00;
   bit [7:0] m_wdata  = 8'h00;

   wire p0   = C0Read_request | C0Write_request;
   wire p1   = C1Read_request | C1Write_request;
   wire pick = (p0 && p1) ? !m_last : p1;
   wire owner_still_wants = m_owner ? (m_wr ? C1Write_request : C1Read_request)
                                    : (m_wr ? C0Write_request : C0Read_request);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         txn_open <= 1'b0; txn_done <= 1'b0; m_owner <= 1'b0; m_wr <= 1'b0;
         m_last <= 1'b1; m_addr <= 8'h00; m_wdata <= 8'h00;
      end else if (!txn_open) begin
         if (p0 || p1) begin
            txn_open <= 1'b1;
            txn_done <= 1'b0;
            m_owner  <= pick;
            m_wr     <= pick ? !C1Read_request : !C0Read_request;
            m_addr   <= pick ? C1Address : C0Address;
            m_wdata  <= pick ? C1Write_data : C0Write_data;
         end
      end else if (!txn_done) begin
         if (m_wr ? MWrite_done : MRead_ready) begin
            txn_done <= 1'b1;
            m_last   <= m_owner;
         end
      end else if (!owner_still_wants) begin
         txn_open <= 1'b0;
      end
   end

   wire active  = txn_open && !txn_done;
   wire exp_mrd = active && !m_wr;
   wire exp_mwr = active && m_wr;
   wire exp_c0r = exp_mrd && !m_owner && MRead_ready;
   wire exp_c1r = exp_mrd &&  m_owner && MRead_ready;
   wire exp_c0w = exp_mwr && !m_owner && MWrite_done;
   wire exp_c1w = exp_mwr &&  m_owner && MWrite_done;

   always @(negedge clk) begin
      if (chk_en) begin
         check("mdl_MRead_request",  MRead_request,  exp_mrd);
         check("mdl_MWrite_request", MWrite_request, exp_mwr);
         check("mdl_MAddress",       MAddress,       m_addr);
         check("mdl_MWrite_data",    MWrite_data,    m_wdata);
         check("mdl_C0Read_ready",   C0Read_ready,   exp_c0r);
         check("mdl_C1Read_ready",   C1Read_ready,   exp_c1r);
         check("mdl_C0Write_done",   C0Write_done,   exp_c0w);
         check("mdl_C1Write_done",   C1Write_done,   exp_c1w);
         check("mdl_C0Read_data",    C0Read_data,    MRead_data);
         check("mdl_C1Read_data",    C1Read_data,    MRead_data);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for a memory request; n = cycles waited.
   task automatic wait_mreq(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(MRead_request || MWrite_request) && n < 20);
      check("wait_mreq", MRead_request | MWrite_request, 1);
   endtask

   logic [7:0] order [4];
   int         n;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      C0Read_request = 0; C0Write_request = 0; C1Read_request = 0; C1Write_request = 0;
      C0Address = 0; C1Address = 0; C0Write_data = 0; C1Write_data = 0;
      MRead_ready = 0; MWrite_done = 0; MRead_data = 0;
      #1 rst = 1'b1;
      chk_en = 1'b1;
      repeat (2) tick();
      check("rst_MRead_request",  MRead_request, 0);
      check("rst_MWrite_request", MWrite_request, 0);
      check("rst_MAddress",       MAddress, 0);
      check("rst_MWrite_data",    MWrite_data, 0);
      check("rst_C0Read_ready",   C0Read_ready, 0);
      rst = 1'b0;
      tick();

      // Lone C0 read
      C0Read_request = 1; C0Address = 8'h03;
      tick();
      check("t1_MRead_request", MRead_request, 1);
      check("t1_MAddress", MAddress, 8'h03);
      tick();
      MRead_data = 32'hBF9FF3FF; MRead_ready = 1; #1;
      check("t1_C0Read_ready", C0Read_ready, 1);
      check("t1_C0Read_data", C0Read_data, 32'hBF9FF3FF);
      check("t1_C1Read_ready", C1Read_ready, 0);
      tick();
      MRead_ready = 0; MRead_data = 0; C0Read_request = 0;
      check("t1_MRead_drop", MRead_request, 0);
      repeat (2) tick();

      // Tie after reset: C0 write wins, then C1 read
      rst = 1; tick(); rst = 0;
      C0Write_request = 1; C0Address = 8'h02; C0Write_data = 8'h01;
      C1Read_request = 1; C1Address = 8'h10;
      tick();
      check("t2_MWrite_request", MWrite_request, 1);
      check("t2_MRead_request", MRead_request, 0);
      check("t2_MWrite_data", MWrite_data, 8'h01);
      check("t2_MAddress", MAddress, 8'h02);
      MWrite_done = 1; #1;
      check("t2_C0Write_done", C0Write_done, 1);
      check("t2_C1Read_ready", C1Read_ready, 0);
      tick();
      MWrite_done = 0; C0Write_request = 0;
      wait_mreq(n);
      check("t2_gap", n, 2);
      check("t2_c1_MRead_request", MRead_request, 1);
      check("t2_c1_MAddress", MAddress, 8'h10);
      MRead_ready = 1; #1;
      check("t2_C1Read_ready", C1Read_ready, 1);
      check("t2_C0Read_ready", C0Read_ready, 0);
      tick();
      MRead_ready = 0; C1Read_request = 0;
      repeat (2) tick();

      // Both reading continuously: grants alternate
      C0Read_request = 1; C0Address = 8'h0A; C1Read_request = 1; C1Address = 8'h0B;
      for (int k = 0; k < 4; k++) begin
         wait_mreq(n);
         order[k] = MAddress;
         MRead_ready = 1;
         tick();
         MRead_ready = 0;
         if (k == 3) begin
            C0Read_request = 0; C1Read_request = 0;
         end else if (order[k] == 8'h0A) begin
            C0Read_request = 0;
         end else begin
            C1Read_request = 0;
         end
         tick();
         if (k < 3) begin
            C0Read_request = 1; C1Read_request = 1;
         end
      end
      check("t3_grant0", order[0], 8'h0A);
      check("t3_grant1", order[1], 8'h0B);
      check("t3_grant2", order[2], 8'h0A);
      check("t3_grant3", order[3], 8'h0B);
      repeat (2) tick();

      // C1 read and write together: read first, then write
      C1Read_request = 1; C1Write_request = 1; C1Address = 8'h20; C1Write_data = 8'h55;
      wait_mreq(n);
      check("t4_MRead_request", MRead_request, 1);
      check("t4_MWrite_request", MWrite_request, 0);
      check("t4_MAddress", MAddress, 8'h20);
      MRead_ready = 1;
      tick();
      MRead_ready = 0; C1Read_request = 0;
      wait_mreq(n);
      check("t4_w_MWrite_request", MWrite_request, 1);
      check("t4_w_MWrite_data", MWrite_data, 8'h55);
      MWrite_done = 1; #1;
      check("t4_C1Write_done", C1Write_done, 1);
      tick();
      MWrite_done = 0; C1Write_request = 0;
      repeat (2) tick();

      // Long completion, owner lingering, C1 waiting behind
      C0Write_request = 1; C0Address = 8'h30; C0Write_data = 8'hA5;
      wait_mreq(n);
      MWrite_done = 1; #1;
      check("t5_C0Write_done_first", C0Write_done, 1);
      tick();
      C1Read_request = 1; C1Address = 8'h40; #1;
      check("t5_C0Write_done_second", C0Write_done, 0);
      check("t5_MWrite_dropped", MWrite_request, 0);
      tick();
      MWrite_done = 0;
      check("t5_hold_a", MRead_request, 0);
      tick();
      check("t5_hold_b", MRead_request | MWrite_request, 0);
      tick();
      C0Write_request = 0;
      check("t5_hold_c", MRead_request, 0);
      wait_mreq(n);
      check("t5_gap", n, 2);
      check("t5_c1_MRead_request", MRead_request, 1);
      check("t5_c1_MAddress", MAddress, 8'h40);
      MRead_ready = 1;
      tick();
      MRead_ready = 0; C1Read_request = 0;
      repeat (2) tick();

      // Reset mid C1 write, stale completion afterwards
      C1Write_request = 1; C1Address = 8'h50; C1Write_data = 8'h77;
      wait_mreq(n);
      check("t6_MWrite_request", MWrite_request, 1);
      tick();
      rst = 1; #1;
      check("t6_rst_MWrite_request", MWrite_request, 0);
      check("t6_rst_MRead_request", MRead_request, 0);
      check("t6_rst_MAddress", MAddress, 0);
      MWrite_done = 1; #1;
      check("t6_rst_C1Write_done", C1Write_done, 0);
      tick();
      rst = 0; #1;
      check("t6_stale_C1Write_done", C1Write_done, 0);
      tick();
      MWrite_done = 0; #1;
      check("t6_regrant_MWrite_request", MWrite_request, 1);
      check("t6_regrant_MAddress", MAddress, 8'h50);
      check("t6_regrant_C1Write_done", C1Write_done, 0);
      MWrite_done = 1; #1;
      check("t6_C1Write_done", C1Write_done, 1);
      tick();
      MWrite_done = 0; C1Write_request = 0;
      repeat (3) tick();

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that lets two cache instances share the single main-memory port. Typical pairing is an instruction cache and a data cache. It sits between the caches' memory-side handshake interfaces and the memory model or controller. It grants the port round-robin, latches the winner's command, forwards the memory's ready/done back to the owner only, and holds the grant until the owner drops its request.

## Interface
- ADDR_W, 8, address width
- WDATA_W, 8, write data width
- RDATA_W, 32, read (line) data width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- C0Read_request / C1Read_request  in  1  requester n read request, level, held until Read_ready seen
- C0Write_request / C1Write_request  in  1  requester n write request, level, held until Write_done seen
- C0Address / C1Address  in  ADDR_W  requester n address, stable while request high
- C0Write_data / C1Write_data  in  WDATA_W  requester n write data
- C0Read_ready / C1Read_ready  out  1  memory read completion, owner only
- C0Read_data / C1Read_data  out  RDATA_W  MRead_data broadcast to both; valid only with own Read_ready
- C0Write_done / C1Write_done  out  1  memory write completion, owner only
- MRead_request  out  1  read request to memory
- MWrite_request  out  1  write request to memory
- MAddress  out  ADDR_W  latched owner address
- MWrite_data  out  WDATA_W  latched owner write data
- MRead_ready  in  1  memory read completion, at least 1 cycle
- MRead_data  in  RDATA_W  read data, valid with MRead_ready
- MWrite_done  in  1  memory write completion, at least 1 cycle

## Operation
- States: IDLE, BUSY, RELEASE. Registers: state, owner (1b), op (0=read, 1=write), last (1b, last granted), MAddress, MWrite_data.
- Requester n is pending when its Read_request or Write_request is high. If both are high, the read is served; the write is taken in the next transaction.
- IDLE:
  - One pending requester: grant it.
  - Both pending: grant ~last.
  - On grant: latch owner, op, address, data; go to BUSY.
  - No pending requester: stay in IDLE.
- BUSY:
  - MRead_request = (op==0) and MWrite_request = (op==1), both registered.
  - Owner's Read_ready = MRead_ready when op==0; owner's Write_done = MWrite_done when op==1. Both are combinational pass-through.
  - Non-owner completion outputs stay 0.
  - On the completion edge: deassert the M request, last <= owner, go to RELEASE.
- RELEASE:
  - Completion outputs are 0.
  - Go to IDLE on the first edge where the owner's request for op is low.
  - Completion inputs arriving in RELEASE or IDLE are ignored.
- A losing requester waits with its request held; nothing is dropped or reordered per requester.
- MAddress and MWrite_data hold their last latched value outside BUSY.

## Timing
- Reset (async assert, sync-safe release): state=IDLE, last=1 (so C0 wins the first tie), owner=0, op=0. All outputs 0, including MAddress and MWrite_data.
- Reset asserted mid-transaction aborts it immediately: M requests drop the same instant, and no completion is forwarded.
- Request high in cycle N (IDLE) → M*_request and MAddress valid from cycle N+1.
- Memory completion in cycle M → owner's Read_ready/Write_done high in cycle M, concurrent with the input. M*_request is low from M+1.
- Owner request low in cycle R (RELEASE) → IDLE at R+1 → next grant visible at R+2.
- Minimum spacing between memory transactions: 2 idle cycles on the M side.
- A completion lasting more than 1 cycle is forwarded only in its first cycle, because the state leaves BUSY.
- No timeout: BUSY waits indefinitely for completion.

## Structure
- A shared package holds the state enum (IDLE/BUSY/RELEASE), the op encoding (OP_READ=0, OP_WRITE=1) and the width defaults.
- One natural sub-module: rr_pick2. It is combinational: inputs pending[1:0] and last; outputs grant_valid and grant_idx. Everything else lives in mem_port_arbiter.

## Test plan
- C0 read only, address 0x03, memory returns 0xBF9FF3FF with MRead_ready 1 cycle → MRead_request high 1 cycle after the request, MAddress=0x03. C0Read_ready pulses with C0Read_data=0xBF9FF3FF. C1Read_ready stays 0.
- C0 write addr 0x02 data 0x01 and C1 read addr 0x10 raised in the same cycle after reset → C0 served first (MWrite_request, MWrite_data=0x01). After C0 drops its request, C1 read issued with MAddress=0x10.
- Both requesters continuously requesting reads for 4 transactions → grants alternate C0, C1, C0, C1.
- C1 asserts read and write together, addr 0x20, data 0x55 → read served first. After release, the write is issued with MWrite_data=0x55.
- Owner holds its request 3 cycles after completion; memory holds MWrite_done high 2 cycles → Write_done forwarded once, no new M request until the owner drops its request, then 2 cycles gap.
- Reset asserted while BUSY on a C1 write → M requests 0 immediately. After reset, a new C1 request is granted; the stale completion input is not forwarded.
